int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt and reset controller sitting directly upstream of the CPU sequencer.
- Synchronises the external n_nmi and n_irq pins and latches NMI edges.
- Arbitrates reset, NMI, BRK and IRQ requests, and hands the sequencer one request at a time through a req/ack handshake.
- While a request is in service it holds the vector address, the request type and the B flag that the sequencer pushes with P.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser; minimum 2.
- RST_VEC, 16'hFFFC, reset vector address.
- NMI_VEC, 16'hFFFA, NMI vector address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector address.

Ports:
- sys.clk  input  1  clock, carried on the sys_if port sys.
- sys.n_reset  input  1  asynchronous active-low reset, carried on sys.
- n_nmi  input  1  external NMI pin, asynchronous, falling-edge active.
- n_irq  input  1  external IRQ pin, asynchronous, level active-low.
- p_i  input  1  current status I flag; 1 masks IRQ.
- int_poll  input  1  sequencer pulse at the instruction boundary (Fetch cycle).
- brk  input  1  sequencer pulse when BRK is decoded.
- int_ack  input  1  sequencer accepts the current request.
- vec_lock  input  1  sequencer pulse on the vector-low fetch cycle.
- int_done  input  1  sequencer pulse when the vector is loaded into PC.
- int_req  output  1  request pending towards the sequencer.
- int_type  output  2  request type: 0 RST, 1 NMI, 2 IRQ, 3 BRK.
- vec_addr  output  16  vector low-byte address; the high byte is at vec_addr+1.
- b_flag  output  1  B bit to push with P; 1 only for BRK.
- nmi_pending  output  1  NMI edge latched and not yet serviced (debug).

Behaviour:
- Reset values: state RST_PEND, int_req=1, int_type=0, vec_addr=RST_VEC, b_flag=0, nmi_pending=0.
  - Synchroniser and edge-history flops reset to 1 (inactive).
- Reset asserted mid-operation aborts everything: returns to RST_PEND, clears the latched type and nmi_pend.
- Synchronisers: SYNC_STAGES flops per pin.
  - NMI edge = previous synced value 1 and current synced value 0. It sets nmi_pend SYNC_STAGES+1 clocks after the pin falls.
  - n_nmi held low through reset produces exactly one edge after release.
- nmi_pend stays set until an NMI is acked, or until NMI hijack (optional feature). A second edge while set is absorbed.
- States:
  - RST_PEND: int_req=1, type RST. On int_ack -> SERVICE.
  - IDLE: int_req=0. Candidate requests are sampled on a cycle with int_poll or brk. Priority: NMI (nmi_pend) > BRK (brk) > IRQ (int_poll & synced irq low & ~p_i). A winner is latched into type -> REQ. With no winner, stay in IDLE.
  - REQ: int_req=1, type/vec_addr/b_flag stable. On int_ack -> SERVICE, with int_req low next cycle. If the type is NMI, nmi_pend clears on the ack cycle; an edge on that same cycle re-sets it.
  - SERVICE: int_req=0, outputs held. On int_done -> IDLE.
- vec_addr is decoded from the latched type: RST -> RST_VEC, NMI -> NMI_VEC, IRQ/BRK -> IRQ_VEC.
- The IRQ level is sampled only at the poll. Deassertion after latching does not cancel the request.
- Ignored inputs:
  - int_poll and brk outside IDLE; pending NMI/IRQ conditions remain for the next poll.
  - int_ack outside RST_PEND/REQ.
  - int_done outside SERVICE.
  - vec_lock without the optional feature.
- int_ack and int_done on the same cycle in REQ: the ack is taken, int_done is ignored.

Optional Feature:
- Macro INT_NMI_HIJACK_EN.
- Enabled:
  - In SERVICE with type IRQ or BRK, a set nmi_pend before vec_lock switches type to NMI and vec_addr to NMI_VEC on the next clock, and clears nmi_pend.
  - b_flag keeps its BRK value; the pushed P still reports BRK.
  - Once vec_lock is seen, the vector is frozen until int_done.
- Disabled: the vector is fixed at the ack. A pending NMI waits for the next int_poll in IDLE. vec_lock is unused.

Test Plan:
1. Release n_reset, hold int_ack low 5 cycles -> int_req=1, int_type=0, vec_addr=16'hFFFC throughout. Pulse int_ack -> int_req=0 next cycle. Pulse int_done -> IDLE.
2. In IDLE, n_irq=0, p_i=1, int_poll pulse -> no request. Then p_i=0, int_poll pulse -> int_req=1, int_type=2, vec_addr=16'hFFFE, b_flag=0.
3. Fall n_nmi at cycle t -> nmi_pending=1 at t+3 (SYNC_STAGES=2). int_poll with n_irq=0, p_i=0 -> int_type=1, vec_addr=16'hFFFA. int_ack clears nmi_pending.
4. brk pulse in IDLE -> int_type=3, b_flag=1, vec_addr=16'hFFFE. A second brk and int_poll during SERVICE are ignored.
5. With INT_NMI_HIJACK_EN: BRK in SERVICE, NMI edge before vec_lock -> vec_addr=16'hFFFA, b_flag=1. Same NMI edge after vec_lock -> vec_addr stays 16'hFFFE, nmi_pending=1 until the next acked NMI.
6. Assert n_reset during SERVICE of an IRQ with nmi_pending=1 -> after release int_type=0, vec_addr=16'hFFFC, nmi_pending=0.

Source files
------------

// File: rtl/int_ctrl_if.sv
// Clock/reset bundle for int_ctrl: clk plus asynchronous active-low n_reset.
interface sys_if;
  logic clk;
  logic n_reset;
  modport dut (input clk, input n_reset);
endinterface

// File: rtl/int_ctrl.sv
// Interrupt/reset controller ahead of the CPU sequencer: pin sync, NMI edge latch, arbitration, req/ack handoff.
// Optional build macro INT_NMI_HIJACK_EN: a pending NMI retargets an IRQ/BRK vector until vec_lock.
module int_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RST_VEC     = 16'hFFFC,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  sys_if.dut          sys,
  input  logic        n_nmi,
  input  logic        n_irq,
  input  logic        p_i,
  input  logic        int_poll,
  input  logic        brk,
  input  logic        int_ack,
  input  logic        vec_lock,
  input  logic        int_done,
  output logic        int_req,
  output logic [1:0]  int_type,
  output logic [15:0] vec_addr,
  output logic        b_flag,
  output logic        nmi_pending
);

  typedef enum logic [1:0] {RST_PEND, IDLE, REQ, SERVICE} state_t;

  localparam logic [1:0] T_RST = 2'd0;
  localparam logic [1:0] T_NMI = 2'd1;
  localparam logic [1:0] T_IRQ = 2'd2;
  localparam logic [1:0] T_BRK = 2'd3;

  state_t                 state;
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   nmi_prev;
  logic                   nmi_pend;
  logic                   nmi_edge;
  logic                   irq_low;
  logic                   nmi_clr;
  logic                   hijack_go;
  logic                   win_vld;
  logic [1:0]             win_type;

  function automatic logic [15:0] vec_of(input logic [1:0] t);
    case (t)
      T_RST:   vec_of = RST_VEC;
      T_NMI:   vec_of = NMI_VEC;
      default: vec_of = IRQ_VEC;
    endcase
  endfunction

  // Sync and edge-history flops idle high so a pin held low through reset yields one edge after release.
  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      nmi_sync <= '1;
      irq_sync <= '1;
      nmi_prev <= 1'b1;
    end else begin
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], n_nmi};
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], n_irq};
      nmi_prev <= nmi_sync[SYNC_STAGES-1];
    end
  end

  assign nmi_edge = nmi_prev & ~nmi_sync[SYNC_STAGES-1];
  assign irq_low  = ~irq_sync[SYNC_STAGES-1];

`ifdef INT_NMI_HIJACK_EN
  logic vec_locked;

  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset)
      vec_locked <= 1'b0;
    else if (state == SERVICE && int_done)
      vec_locked <= 1'b0;
    else if (state == SERVICE && vec_lock)
      vec_locked <= 1'b1;
  end

  // A vec_lock on the same cycle already fixes the vector, so it blocks the switch.
  assign hijack_go = (state == SERVICE) && !int_done && nmi_pend &&
                     ((int_type == T_IRQ) || (int_type == T_BRK)) &&
                     !vec_locked && !vec_lock;
`else
  logic unused_vec_lock;
  assign unused_vec_lock = vec_lock;
  assign hijack_go       = 1'b0;
`endif

  assign nmi_clr = ((state == REQ) && int_ack && (int_type == T_NMI)) || hijack_go;

  // A fresh edge wins over a clear on the same cycle.
  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset)
      nmi_pend <= 1'b0;
    else
      nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);
  end

  assign nmi_pending = nmi_pend;

  always_comb begin
    win_vld  = 1'b0;
    win_type = T_RST;
    if (int_poll || brk) begin
      if (nmi_pend) begin
        win_vld  = 1'b1;
        win_type = T_NMI;
      end else if (brk) begin
        win_vld  = 1'b1;
        win_type = T_BRK;
      end else if (int_poll && irq_low && !p_i) begin
        win_vld  = 1'b1;
        win_type = T_IRQ;
      end
    end
  end

  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      state    <= RST_PEND;
      int_req  <= 1'b1;
      int_type <= T_RST;
      vec_addr <= RST_VEC;
      b_flag   <= 1'b0;
    end else begin
      case (state)
        RST_PEND: if (int_ack) begin
          state   <= SERVICE;
          int_req <= 1'b0;
        end
        IDLE: if (win_vld) begin
          state    <= REQ;
          int_req  <= 1'b1;
          int_type <= win_type;
          vec_addr <= vec_of(win_type);
          b_flag   <= (win_type == T_BRK);
        end
        REQ: if (int_ack) begin
          state   <= SERVICE;
          int_req <= 1'b0;
        end
        SERVICE: begin
          if (int_done)
            state <= IDLE;
          else if (hijack_go) begin
            int_type <= T_NMI;
            vec_addr <= NMI_VEC;
          end
        end
        default: begin
          state   <= RST_PEND;
          int_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed plus randomized bench for int_ctrl, checked against a transaction-level reference model.
module tb_int_ctrl;
  localparam int          S  = 2;
  localparam logic [15:0] RV = 16'hFFFC;
  localparam logic [15:0] NV = 16'hFFFA;
  localparam logic [15:0] IV = 16'hFFFE;

  sys_if sysb ();
  logic        n_nmi, n_irq, p_i, int_poll, brk, int_ack, vec_lock, int_done;
  logic        int_req, b_flag, nmi_pending;
  logic [1:0]  int_type;
  logic [15:0] vec_addr;
  int          n_chk = 0;
  int          n_err = 0;

  int_ctrl #(.SYNC_STAGES(S)) dut (
    .sys(sysb), .n_nmi(n_nmi), .n_irq(n_irq), .p_i(p_i), .int_poll(int_poll),
    .brk(brk), .int_ack(int_ack), .vec_lock(vec_lock), .int_done(int_done),
    .int_req(int_req), .int_type(int_type), .vec_addr(vec_addr),
    .b_flag(b_flag), .nmi_pending(nmi_pending)
  );

  initial sysb.clk = 1'b0;
  always #5 sysb.clk = ~sysb.clk;

  // Reference model: pin histories plus "what the sequencer is owed" flags.
  bit nq[$];
  bit iq[$];
  bit m_boot, m_req, m_svc, m_pend, m_lock, m_b;
  int m_type;

  function automatic logic [15:0] m_vec();
    if (m_type == 0) return RV;
    if (m_type == 1) return NV;
    return IV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("int_req",  int_req,     m_boot || m_req);
    chk("int_type", int_type,    m_type);
    chk("vec_addr", vec_addr,    m_vec());
    chk("b_flag",   b_flag,      m_b);
    chk("nmi_pend", nmi_pending, m_pend);
  endtask

  task automatic model_reset();
    nq.delete();
    iq.delete();
    for (int k = 0; k <= S; k++) begin
      nq.push_back(1'b1);
      iq.push_back(1'b1);
    end
    m_boot = 1; m_req = 0; m_svc = 0; m_pend = 0; m_lock = 0; m_b = 0; m_type = 0;
  endtask

  // Evaluate one clock edge from the inputs currently applied.
  task automatic model_edge();
    bit edge_s, irq_lo, clr;
    edge_s = nq[S] && !nq[S-1];
    irq_lo = !iq[S-1];
    clr    = 0;
    if (m_boot) begin
      if (int_ack) begin m_boot = 0; m_svc = 1; end
    end else if (m_req) begin
      if (int_ack) begin
        m_req = 0; m_svc = 1;
        if (m_type == 1) clr = 1;
      end
    end else if (m_svc) begin
      if (int_done) begin m_svc = 0; m_lock = 0; end
`ifdef INT_NMI_HIJACK_EN
      else begin
        if (m_pend && m_type >= 2 && !m_lock && !vec_lock) begin m_type = 1; clr = 1; end
        if (vec_lock) m_lock = 1;
      end
`endif
    end else if (int_poll || brk) begin
      if (m_pend)                           begin m_type = 1; m_b = 0; m_req = 1; end
      else if (brk)                         begin m_type = 3; m_b = 1; m_req = 1; end
      else if (int_poll && irq_lo && !p_i)  begin m_type = 2; m_b = 0; m_req = 1; end
    end
    m_pend = edge_s || (m_pend && !clr);
    nq.push_front(n_nmi); void'(nq.pop_back());
    iq.push_front(n_irq); void'(iq.pop_back());
  endtask

  task automatic tick();
    model_edge();
    @(posedge sysb.clk);
    #1;
    chk_model();
  endtask

  task automatic clr_pulses();
    int_poll = 0; brk = 0; int_ack = 0; vec_lock = 0; int_done = 0;
  endtask

  task automatic do_reset();
    sysb.n_reset = 1'b0;
    model_reset();
    #1;
    chk("rst_req",  int_req, 1'b1);
    chk("rst_type", int_type, 2'd0);
    chk("rst_vec",  vec_addr, RV);
    chk("rst_pend", nmi_pending, 1'b0);
    chk("rst_b",    b_flag, 1'b0);
    repeat (2) @(posedge sysb.clk);
    #1 sysb.n_reset = 1'b1;
  endtask

  initial begin
    n_nmi = 1; n_irq = 1; p_i = 1;
    clr_pulses();
    sysb.n_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge sysb.clk);
    #1;
    chk_model();
    sysb.n_reset = 1'b1;

    // 1: boot request held until ack, then service, then done
    repeat (5) begin
      tick();
      chk("t1_req", int_req, 1'b1);
      chk("t1_vec", vec_addr, 16'hFFFC);
    end
    int_ack = 1; tick(); int_ack = 0;
    chk("t1_ack_req", int_req, 1'b0);
    int_done = 1; tick(); int_done = 0;

    // 2: IRQ masked, then unmasked
    n_irq = 0; repeat (3) tick();
    int_poll = 1; tick(); int_poll = 0;
    chk("t2_masked", int_req, 1'b0);
    p_i = 0;
    int_poll = 1; tick(); int_poll = 0;
    chk("t2_req", int_req, 1'b1);
    chk("t2_type", int_type, 2'd2);
    chk("t2_vec", vec_addr, 16'hFFFE);
    chk("t2_b", b_flag, 1'b0);
    int_ack = 1; tick(); int_ack = 0;
    int_done = 1; tick(); int_done = 0;

    // 3: NMI latency and priority over IRQ
    n_nmi = 0;
    tick(); tick();
    chk("t3_pend_early", nmi_pending, 1'b0);
    tick();
    chk("t3_pend_t3", nmi_pending, 1'b1);
    int_poll = 1; tick(); int_poll = 0;
    chk("t3_type", int_type, 2'd1);
    chk("t3_vec", vec_addr, 16'hFFFA);
    int_ack = 1; tick(); int_ack = 0;
    chk("t3_ack_clr", nmi_pending, 1'b0);
    int_done = 1; tick(); int_done = 0;
    n_nmi = 1; n_irq = 1; p_i = 1;
    repeat (3) tick();

    // 4: BRK, and BRK/poll ignored in SERVICE
    brk = 1; tick(); brk = 0;
    chk("t4_type", int_type, 2'd3);
    chk("t4_b", b_flag, 1'b1);
    chk("t4_vec", vec_addr, 16'hFFFE);
    int_ack = 1; tick(); int_ack = 0;
    brk = 1; int_poll = 1; tick(); clr_pulses();
    chk("t4_ign_req", int_req, 1'b0);
    int_done = 1; tick(); int_done = 0;

`ifdef INT_NMI_HIJACK_EN
    // 5: hijack before vec_lock, none after
    brk = 1; tick(); brk = 0;
    int_ack = 1; tick(); int_ack = 0;
    n_nmi = 0; repeat (4) tick();
    chk("t5_hij_vec", vec_addr, 16'hFFFA);
    chk("t5_hij_b", b_flag, 1'b1);
    chk("t5_hij_pend", nmi_pending, 1'b0);
    vec_lock = 1; tick(); vec_lock = 0;
    int_done = 1; tick(); int_done = 0;
    n_nmi = 1; repeat (3) tick();
    brk = 1; tick(); brk = 0;
    int_ack = 1; tick(); int_ack = 0;
    vec_lock = 1; tick(); vec_lock = 0;
    n_nmi = 0; repeat (4) tick();
    chk("t5_lock_vec", vec_addr, 16'hFFFE);
    chk("t5_lock_pend", nmi_pending, 1'b1);
    int_done = 1; tick(); int_done = 0;
    int_poll = 1; tick(); int_poll = 0;
    int_ack = 1; tick(); int_ack = 0;
    chk("t5_nmi_clr", nmi_pending, 1'b0);
    int_done = 1; tick(); int_done = 0;
    n_nmi = 1; repeat (3) tick();
`endif

    // 6: reset during IRQ service with NMI pending; pin kept low through reset
    n_irq = 0; p_i = 0; repeat (3) tick();
    int_poll = 1; tick(); int_poll = 0;
    int_ack = 1; tick(); int_ack = 0;
    vec_lock = 1; tick(); vec_lock = 0;
    n_nmi = 0; repeat (3) tick();
    chk("t6_pend_set", nmi_pending, 1'b1);
    do_reset();
    chk("t6_type", int_type, 2'd0);
    chk("t6_vec", vec_addr, 16'hFFFC);
    chk("t6_pend", nmi_pending, 1'b0);
    repeat (3) tick();
    chk("t6_one_edge", nmi_pending, 1'b1);
    n_nmi = 1; n_irq = 1; p_i = 1;
    int_ack = 1; tick(); int_ack = 0;
    int_done = 1; tick(); int_done = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) n_nmi = ~n_nmi;
      if ($urandom_range(7) == 0) n_irq = ~n_irq;
      if ($urandom_range(7) == 0) p_i   = ~p_i;
      int_poll = ($urandom_range(3) == 0);
      brk      = ($urandom_range(15) == 0);
      int_ack  = ($urandom_range(2) == 0);
      vec_lock = ($urandom_range(3) == 0);
      int_done = ($urandom_range(3) == 0);
      if ($urandom_range(499) == 0) begin
        clr_pulses();
        do_reset();
      end else begin
        tick();
      end
    end
    clr_pulses();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
